// File: rtl/metro_pkg.sv
// Shared constants for the station-board display stages: active-high a..g
// segment codes (bit 6 = a, bit 0 = g) and the all-off anode pattern.
package metro_pkg;

  localparam logic [3:0] AN_OFF = 4'b1111;

  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_G     = 7'h5E;
  localparam logic [6:0] SEG_H     = 7'h37;
  localparam logic [6:0] SEG_I     = 7'h06;
  localparam logic [6:0] SEG_J     = 7'h3C;
  localparam logic [6:0] SEG_L     = 7'h0E;
  localparam logic [6:0] SEG_N     = 7'h76;
  localparam logic [6:0] SEG_O     = 7'h7E;
  localparam logic [6:0] SEG_P     = 7'h67;
  localparam logic [6:0] SEG_R     = 7'h46;
  localparam logic [6:0] SEG_S     = 7'h5B;
  localparam logic [6:0] SEG_T     = 7'h0F;
  localparam logic [6:0] SEG_U     = 7'h3E;
  localparam logic [6:0] SEG_Y     = 7'h3B;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;

  localparam logic [6:0] SEG_DASH  = 7'h01;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_char_rom.sv
// Combinational ASCII to active-high seven-segment lookup; anything outside
// the supported character set shows blank.
module seg_char_rom
  import metro_pkg::*;
(
  input  logic [7:0] ascii_i,
  output logic [6:0] pattern_o
);

  always_comb begin
    pattern_o = SEG_BLANK;
    unique case (ascii_i)
      8'h41: pattern_o = SEG_A;
      8'h42: pattern_o = SEG_B;
      8'h43: pattern_o = SEG_C;
      8'h44: pattern_o = SEG_D;
      8'h45: pattern_o = SEG_E;
      8'h47: pattern_o = SEG_G;
      8'h48: pattern_o = SEG_H;
      8'h49: pattern_o = SEG_I;
      8'h4A: pattern_o = SEG_J;
      8'h4C: pattern_o = SEG_L;
      8'h4E: pattern_o = SEG_N;
      8'h4F: pattern_o = SEG_O;
      8'h50: pattern_o = SEG_P;
      8'h52: pattern_o = SEG_R;
      8'h53: pattern_o = SEG_S;
      8'h54: pattern_o = SEG_T;
      8'h55: pattern_o = SEG_U;
      8'h59: pattern_o = SEG_Y;
      8'h30: pattern_o = SEG_0;
      8'h31: pattern_o = SEG_1;
      8'h32: pattern_o = SEG_2;
      8'h33: pattern_o = SEG_3;
      8'h34: pattern_o = SEG_4;
      8'h35: pattern_o = SEG_5;
      8'h36: pattern_o = SEG_6;
      8'h37: pattern_o = SEG_7;
      8'h38: pattern_o = SEG_8;
      8'h39: pattern_o = SEG_9;
      8'h2D: pattern_o = SEG_DASH;
      default: pattern_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode scan driver: accepts a word into a pending slot and
// promotes it to the visible word only at a frame boundary.
module seg_scan_driver
  import metro_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_tick
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [31:0] WORD_SPACES = {4{8'h20}};

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic [31:0]   disp_q, disp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_tick_q, frame_tick_d;

  logic          tick, boundary, xfer, promote;
  logic [7:0]    disp_bytes [4];
  logic [6:0]    rom_pattern;

  assign tick     = (div_q == DIV_LAST);
  assign boundary = tick && (idx_q == 2'd3);
  assign xfer     = char_valid && !pend_full_q;
  // A word transferred on the boundary cycle is not yet in pend_q, so it
  // naturally waits for the following frame.
  assign promote  = boundary && pend_full_q;

  // Decode from the next-state word/index so the new word is visible in the
  // same registered update that lights digit 0.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign disp_bytes[gi] = disp_d[gi*8 +: 8];
    end
  endgenerate

  seg_char_rom u_rom (
    .ascii_i   (disp_bytes[idx_d]),
    .pattern_o (rom_pattern)
  );

  always_comb begin
    div_d        = tick ? '0 : div_q + 1'b1;
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    disp_d       = promote ? pend_q : disp_q;
    pend_d       = xfer ? char_in : pend_q;
    pend_full_d  = pend_full_q;
    if (promote) pend_full_d = 1'b0;
    if (xfer)    pend_full_d = 1'b1;
    an_d         = tick ? ~(4'b0001 << idx_d) : an_q;
    seg_d        = tick ? ~rom_pattern : seg_q;
    frame_tick_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= 2'd3;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      disp_q       <= WORD_SPACES;
      an_q         <= AN_OFF;
      seg_q        <= 7'h7F;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      disp_q       <= disp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign char_ready = !pend_full_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver with a cycle-count based reference model.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] char_in;
  logic        char_valid;
  logic        char_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_tick;

  int n_pass = 0;
  int n_total = 0;

  // Model state: k = clock edges since the last reset edge.
  int          k;
  logic [31:0] m_disp;
  logic [31:0] m_pend;
  bit          m_pend_v;
  bit          m_acc;
  logic [6:0]  lut [256];

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %h expected %h", tag, k, got, exp);
  endtask

  function automatic bit is_boundary(input int e);
    return (e >= SD) && ((e - SD) % FRAME == 0);
  endfunction

  // One clock: advance the model on the edge, then compare all outputs.
  task automatic step();
    int d;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    @(posedge clk);
    m_acc = 1'b0;
    if (rst) begin
      k = 0;
      m_pend_v = 1'b0;
      m_disp = {4{8'h20}};
    end else begin
      k++;
      m_acc = char_valid && !m_pend_v;
      if (is_boundary(k) && m_pend_v) begin
        m_disp = m_pend;
        m_pend_v = 1'b0;
      end
      if (m_acc) begin
        m_pend = char_in;
        m_pend_v = 1'b1;
      end
    end
    #1;
    if (k < SD) begin
      e_an = 4'b1111;
      e_seg = 7'h7F;
    end else begin
      d = ((k - SD) / SD) % 4;
      e_an = ~(4'b0001 << d);
      e_seg = ~lut[m_disp[d*8 +: 8]];
    end
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("char_ready", 32'(char_ready), 32'(!m_pend_v));
    check("frame_tick", 32'(frame_tick), 32'(is_boundary(k)));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold the word until the model says it was accepted.
  task automatic send(input logic [31:0] w, input bit keep_valid);
    int budget;
    budget = 0;
    char_in = w;
    char_valid = 1'b1;
    m_acc = 1'b0;
    while (!m_acc && budget < 100) begin
      step();
      budget++;
    end
    if (!m_acc) check("send_timeout", 32'd0, 32'd1);
    $display("sent word %h after %0d cycles (edge %0d)", w, budget, k);
    if (!keep_valid) char_valid = 1'b0;
  endtask

  function automatic logic [7:0] rand_char();
    string cs;
    cs = "ABCDEGHIJLNOPRSTUY0123456789- z";
    return cs[$urandom_range(cs.len() - 1)];
  endfunction

  function automatic logic [31:0] rand_word();
    return {rand_char(), rand_char(), rand_char(), rand_char()};
  endfunction

  initial begin
    string      chars;
    logic [6:0] codes [30];
    codes = '{7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h5E, 7'h37, 7'h06, 7'h3C,
              7'h0E, 7'h76, 7'h7E, 7'h67, 7'h46, 7'h5B, 7'h0F, 7'h3E, 7'h3B,
              7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F,
              7'h7B, 7'h01, 7'h00};
    chars = "ABCDEGHIJLNOPRSTUY0123456789- ";
    for (int i = 0; i < 256; i++) lut[i] = 7'h00;
    for (int i = 0; i < 30; i++) lut[chars[i]] = codes[i];

    k = 0;
    m_pend = '0;
    m_pend_v = 1'b0;
    m_disp = {4{8'h20}};
    rst = 1'b1;
    char_valid = 1'b0;
    char_in = '0;

    // Reset then idle for more than two frames.
    step();
    rst = 1'b0;
    run(2 * FRAME + 5);

    // Mid-frame "GRJ-".
    send({"G", "R", "J", "-"}, 1'b0);
    run(FRAME + 6);

    // Unknown byte in digit 1.
    send({"A", "B", 8'h7A, "9"}, 1'b0);
    run(FRAME + 3);

    // Transfer exactly on a boundary cycle.
    for (int rep = 0; rep < 3; rep++) begin
      while (!(is_boundary(k + 1) && !m_pend_v)) step();
      send(rand_word(), 1'b0);
      run(2 * FRAME + $urandom_range(5));
    end

    // Back-to-back words with valid held high.
    for (int rep = 0; rep < 3; rep++) begin
      send(rand_word(), 1'b1);
      send(rand_word(), 1'b0);
      run(2 * FRAME + $urandom_range(7));
    end

    // Random traffic with random gaps.
    for (int rep = 0; rep < 20; rep++) begin
      run($urandom_range(25));
      send(rand_word(), 1'b0);
    end
    run(2 * FRAME);

    // Reset with a word pending; it must never be shown.
    run(3);
    send({"S", "T", "O", "P"}, 1'b1);
    rst = 1'b1;
    step();
    char_valid = 1'b0;
    rst = 1'b0;
    run(3 * FRAME);

    // Traffic after the mid-operation reset.
    for (int rep = 0; rep < 5; rep++) begin
      run($urandom_range(20));
      send(rand_word(), 1'b0);
    end
    run(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
